// File: rtl/multi_byte_add_pkg.sv
// ----------------------------------------------------------------------------
// multi_byte_add_pkg
// Shared definitions for the byte-serial wide adder:
//   - state_e   : controller states (IDLE, RUN, DONE)
//   - BYTE_W    : width of the shared adder core
//   - WORDS_MIN / WORDS_MAX : legal range of the operand width in bytes
// ----------------------------------------------------------------------------
package multi_byte_add_pkg;

    localparam int BYTE_W    = 8;
    localparam int WORDS_MIN = 2;
    localparam int WORDS_MAX = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add8_core.sv
// ----------------------------------------------------------------------------
// add8_core
// Combinational 8-bit ripple-carry adder built from 1-bit full adders.
// Ports:
//   a[7:0], b[7:0] : addends
//   cin            : carry into bit 0
//   sum[7:0]       : a + b + cin (low 8 bits)
//   cout           : carry out of bit 7
// ----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module add8_core (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] carry_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry_s[i]),
            .sum  (sum[i]),
            .cout (carry_s[i+1])
        );
    end

    assign cout = carry_s[8];
endmodule

// File: rtl/multi_byte_add_seq.sv
// ----------------------------------------------------------------------------
// multi_byte_add_seq
// Adds two WORDS-byte operands by running one shared 8-bit adder core over
// the bytes, least significant first, one byte per clock. The carry between
// bytes is kept in a register. Latency: done pulses WORDS edges after the
// accepted start edge.
// Optional feature macro: MULTI_BYTE_ADD_SEQ_SUB_EN (adds the 'sub' port for
// a - b via b inversion and a forced initial carry of 1).
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   start  : request, only looked at while busy=0
//   a, b   : operands (8*WORDS bits), captured on the accepted start
//   cin    : initial carry, captured on the accepted start
//   sub    : (macro only) subtract instead of add, captured on start
//   busy   : operation in progress (RUN and DONE)
//   done   : one-cycle pulse, sum/cout valid
//   sum    : result, held until the next accepted start
//   cout   : carry out of the top byte (no-borrow flag when subtracting)
// ----------------------------------------------------------------------------
module multi_byte_add_seq
    import multi_byte_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [8*WORDS-1:0]      a,
    input  logic [8*WORDS-1:0]      b,
    input  logic                    cin,
`ifdef MULTI_BYTE_ADD_SEQ_SUB_EN
    input  logic                    sub,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [8*WORDS-1:0]      sum,
    output logic                    cout
);

    localparam int W     = WORDS * BYTE_W;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [W-1:0]     a_q,     a_d;
    logic [W-1:0]     b_q,     b_d;
    logic [W-1:0]     sum_q,   sum_d;
    logic             carry_q, carry_d;
    logic             cout_q,  cout_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
`ifdef MULTI_BYTE_ADD_SEQ_SUB_EN
    logic             sub_q,   sub_d;
`endif

    logic [BYTE_W-1:0] core_a_s;
    logic [BYTE_W-1:0] core_b_s;
    logic [BYTE_W-1:0] b_byte_s;
    logic [BYTE_W-1:0] core_sum_s;
    logic              core_cout_s;

    // Select the current operand bytes for the shared core.
    always_comb begin
        core_a_s = a_q[BYTE_W*int'(idx_q) +: BYTE_W];
        b_byte_s = b_q[BYTE_W*int'(idx_q) +: BYTE_W];
`ifdef MULTI_BYTE_ADD_SEQ_SUB_EN
        // Subtraction is a + ~b + 1; the +1 comes from the initial carry.
        if (sub_q) begin
            core_b_s = ~b_byte_s;
        end else begin
            core_b_s = b_byte_s;
        end
`else
        core_b_s = b_byte_s;
`endif
    end

    add8_core u_core (
        .a    (core_a_s),
        .b    (core_b_s),
        .cin  (carry_q),
        .sum  (core_sum_s),
        .cout (core_cout_s)
    );

    // Controller next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef MULTI_BYTE_ADD_SEQ_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = {IDX_W{1'b0}};
                    sum_d   = {W{1'b0}};
                    cout_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef MULTI_BYTE_ADD_SEQ_SUB_EN
                    sub_d   = sub;
                    if (sub) begin
                        carry_d = 1'b1;
                    end else begin
                        carry_d = cin;
                    end
`else
                    carry_d = cin;
`endif
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[BYTE_W*int'(idx_q) +: BYTE_W] = core_sum_s;
                carry_d = core_cout_s;
                busy_d  = 1'b1;
                if (idx_q == IDX_LAST) begin
                    // Last byte: publish the final carry, idx stays in range.
                    cout_d  = core_cout_s;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                // start is deliberately not sampled here.
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= {IDX_W{1'b0}};
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            sum_q   <= {W{1'b0}};
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULTI_BYTE_ADD_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MULTI_BYTE_ADD_SEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_multi_byte_add_seq.sv
// ----------------------------------------------------------------------------
// tb_multi_byte_add_seq
// Directed scoreboard bench for multi_byte_add_seq (WORDS=4). Stimulus pushes
// hand-computed results into a queue; a monitor pops on every done pulse and
// compares sum, cout and the done cycle, then checks sum holds a cycle later.
// ----------------------------------------------------------------------------
module tb_multi_byte_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef MULTI_BYTE_ADD_SEQ_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    multi_byte_add_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef MULTI_BYTE_ADD_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           done_cyc;
        string        tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp     = 0;
    int   n_fail    = 0;
    int   n_push    = 0;
    int   n_done    = 0;
    logic hold_pend = 1'b0;
    logic [W-1:0] hold_sum;
    logic         hold_cout;
    string        hold_tag;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
        end
    endtask

    // Monitor: compare every done pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst !== 1'b1 && done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.tag, " sum"},   {32'd0, sum},  {32'd0, mon_e.sum});
                check({mon_e.tag, " cout"},  {63'd0, cout}, {63'd0, mon_e.cout});
                check({mon_e.tag, " cycle"}, 64'(cyc),      64'(mon_e.done_cyc));
                hold_pend = 1'b1;
                hold_sum  = mon_e.sum;
                hold_cout = mon_e.cout;
                hold_tag  = mon_e.tag;
            end
        end else if (hold_pend) begin
            check({hold_tag, " hold sum"},  {32'd0, sum},  {32'd0, hold_sum});
            check({hold_tag, " hold cout"}, {63'd0, cout}, {63'd0, hold_cout});
            hold_pend = 1'b0;
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle: got busy=1 for 100 cycles, expected 0");
        end
    endtask

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input logic sv);
        a   = av;
        b   = bv;
        cin = cv;
`ifdef MULTI_BYTE_ADD_SEQ_SUB_EN
        sub = sv;
`else
        if (sv) $display("note: subtract request ignored in add-only build");
`endif
    endtask

    task automatic push(input logic [W-1:0] s, input logic c, input string tag);
        exp_t e;
        e.sum      = s;
        e.cout     = c;
        e.done_cyc = cyc + WORDS;
        e.tag      = tag;
        exp_q.push_back(e);
        n_push++;
    endtask

    // Issue one operation; called at a negedge.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input logic sv,
                         input logic [W-1:0] s_exp, input logic c_exp, input string tag);
        wait_idle();
        drive(av, bv, cv, sv);
        start = 1'b1;
        @(negedge clk);
        check({tag, " accept"}, {63'd0, busy}, 64'd1);
        push(s_exp, c_exp, tag);
        start = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t held[3];

    initial begin
        int k;
        logic prev_busy;
        int idx;

        rst   = 1'b1;
        start = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset sum",  {32'd0, sum},  64'd0);
        check("reset cout", {63'd0, cout}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, "ff_plus_1");
        issue(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, "carry_chain");
        issue(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, "top_overflow");
        issue(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 32'h00000000, 1'b1, "alt_bits");
        issue(32'h01020304, 32'h10203040, 1'b0, 1'b0, 32'h11223344, 1'b0, "bytewise");

        // Operands change while busy; result must use the latched values.
        issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, "latched_ops");
        drive(32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Reset two edges after start discards the operation.
        wait_idle();
        drive(32'h11111111, 32'h22222222, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset busy", {63'd0, busy}, 64'd0);
        check("midreset done", {63'd0, done}, 64'd0);
        check("midreset sum",  {32'd0, sum},  64'd0);
        check("midreset cout", {63'd0, cout}, 64'd0);
        issue(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, "after_reset");

        // start held high: each acceptance latches the operands then present.
        held[0] = '{32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0};
        held[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};
        held[2] = '{32'hFFFF0000, 32'h0001FFFF, 1'b0, 32'h0000FFFF, 1'b1};
        wait_idle();
        drive(held[0].a, held[0].b, held[0].cin, 1'b0);
        start     = 1'b1;
        prev_busy = 1'b0;
        idx       = 0;
        k         = 0;
        while (idx < 3 && k < 200) begin
            @(negedge clk);
            k++;
            if (busy === 1'b1 && prev_busy === 1'b0) begin
                push(held[idx].s, held[idx].c, $sformatf("held_%0d", idx));
                idx++;
                if (idx < 3) begin
                    drive(held[idx].a, held[idx].b, held[idx].cin, 1'b0);
                end else begin
                    start = 1'b0;
                end
            end
            prev_busy = busy;
        end
        start = 1'b0;
        if (idx < 3) begin
            n_cmp++;
            n_fail++;
            $display("FAIL held_start: got %0d acceptances, expected 3", idx);
        end

`ifdef MULTI_BYTE_ADD_SEQ_SUB_EN
        issue(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, "sub_borrow");
        issue(32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, "sub_noborrow");
`endif

        // Drain the scoreboard.
        k = 0;
        while ((exp_q.size() != 0 || hold_pend) && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        check("queue empty", 64'(exp_q.size()), 64'd0);
        check("done count",  64'(n_done),       64'(n_push));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
